// File: rtl/div_unit_if.sv
// Start/ready handshake between the control unit (master) and the divider (slave).
// Operands travel master->slave, results and status slave->master.
interface div_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             ready;
    logic             div_zero;

    modport master (
        output start, a, b,
        input  hi, lo, ready, div_zero
    );

    modport slave (
        input  start, a, b,
        output hi, lo, ready, div_zero
    );
endinterface

// File: rtl/div_unit.sv
// Sequential restoring divider: one quotient bit per cycle on operand magnitudes,
// then one sign-fix cycle. hi = remainder, lo = quotient (MIPS DIV/DIVU semantics).
module div_unit #(
    parameter int WIDTH  = 32,
    parameter bit SIGNED = 1'b1
) (
    input logic       clk,
    input logic       reset,
    div_unit_if.slave bus
);
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

    state_t           state, state_next;
    logic [WIDTH:0]   rem;
    logic [WIDTH-1:0] quo, dvs, hi_q, lo_q;
    logic [CW-1:0]    cnt;
    logic             sign_q, sign_r, ready_q, div_zero_q;

    logic             accept, b_is_zero, last_iter;
    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH+1:0] rem_shift, trial;

    assign accept    = bus.start && (state == IDLE || state == DONE);
    assign b_is_zero = (bus.b == '0);
    assign last_iter = (cnt == CW'(WIDTH - 1));

    // Magnitude of the most negative value wraps to itself, which is its correct unsigned magnitude.
    assign a_neg = SIGNED && bus.a[WIDTH-1];
    assign b_neg = SIGNED && bus.b[WIDTH-1];
    assign a_mag = a_neg ? -bus.a : bus.a;
    assign b_mag = b_neg ? -bus.b : bus.b;

    // Extra top bit keeps the borrow visible even when the shifted remainder exceeds WIDTH bits.
    assign rem_shift = {rem, quo[WIDTH-1]};
    assign trial     = rem_shift - {2'b00, dvs};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        // NOTE: default assigned first so every path drives state_next and no latch is inferred.
        state_next = state;
        case (state)
            IDLE, DONE: state_next = accept ? (b_is_zero ? DONE : RUN) : IDLE;
            RUN:        state_next = last_iter ? FIX : RUN;
            FIX:        state_next = DONE;
            default:    state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rem        <= '0;
            quo        <= '0;
            dvs        <= '0;
            cnt        <= '0;
            sign_q     <= 1'b0;
            sign_r     <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
            ready_q    <= 1'b0;
            div_zero_q <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values, independent of statement order.
            ready_q    <= (state_next == DONE);
            div_zero_q <= accept && b_is_zero;
            case (state)
                IDLE, DONE: begin
                    if (accept && !b_is_zero) begin
                        quo    <= a_mag;
                        dvs    <= b_mag;
                        rem    <= '0;
                        sign_q <= a_neg ^ b_neg;
                        sign_r <= a_neg;
                        cnt    <= '0;
                    end
                end
                RUN: begin
                    quo <= {quo[WIDTH-2:0], ~trial[WIDTH+1]};
                    rem <= trial[WIDTH+1] ? rem_shift[WIDTH:0] : trial[WIDTH:0];
                    cnt <= cnt + CW'(1);
                end
                FIX: begin
                    lo_q <= sign_q ? -quo : quo;
                    hi_q <= sign_r ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];
                end
                default: ;
            endcase
        end
    end

    assign bus.hi       = hi_q;
    assign bus.lo       = lo_q;
    assign bus.ready    = ready_q;
    assign bus.div_zero = div_zero_q;
endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: latency, signed results, divide-by-zero, overflow,
// start during RUN, back-to-back starts and mid-operation reset.
module tb_div_unit;
    logic clk;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    div_unit_if #(.WIDTH(32)) bus ();

    div_unit #(.WIDTH(32), .SIGNED(1'b1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Presents operands before edge E0 and returns #1 after it with start dropped.
    task automatic start_div(input logic [31:0] av, input logic [31:0] bv);
        @(negedge clk);
        bus.a     = av;
        bus.b     = bv;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    // Counts edges from E0 (inclusive) until ready is seen; bounded.
    task automatic wait_ready(output int lat);
        lat = 1;
        while (!bus.ready && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic test_reset;
        total++; if (bus.hi !== 32'h0) begin bad++; $display("FAIL reset_hi got=%h exp=%h", bus.hi, 32'h0); end
        total++; if (bus.lo !== 32'h0) begin bad++; $display("FAIL reset_lo got=%h exp=%h", bus.lo, 32'h0); end
        total++; if (bus.ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b exp=0", bus.ready); end
        total++; if (bus.div_zero !== 1'b0) begin bad++; $display("FAIL reset_div_zero got=%b exp=0", bus.div_zero); end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_basic;
        int lat;
        start_div(32'd7, 32'd2);
        wait_ready(lat);
        total++; if (lat !== 34) begin bad++; $display("FAIL basic_latency got=%0d exp=34", lat); end
        total++; if (bus.lo !== 32'd3) begin bad++; $display("FAIL basic_lo got=%h exp=%h", bus.lo, 32'd3); end
        total++; if (bus.hi !== 32'd1) begin bad++; $display("FAIL basic_hi got=%h exp=%h", bus.hi, 32'd1); end
        total++; if (bus.div_zero !== 1'b0) begin bad++; $display("FAIL basic_div_zero got=%b exp=0", bus.div_zero); end
        @(posedge clk); #1;
        total++; if (bus.ready !== 1'b0) begin bad++; $display("FAIL basic_ready_pulse got=%b exp=0", bus.ready); end
    endtask

    task automatic test_signed;
        int lat;
        start_div(32'hFFFF_FFF9, 32'd2);
        wait_ready(lat);
        total++; if (lat !== 34) begin bad++; $display("FAIL neg_dividend_latency got=%0d exp=34", lat); end
        total++; if (bus.lo !== 32'hFFFF_FFFD) begin bad++; $display("FAIL neg_dividend_lo got=%h exp=%h", bus.lo, 32'hFFFF_FFFD); end
        total++; if (bus.hi !== 32'hFFFF_FFFF) begin bad++; $display("FAIL neg_dividend_hi got=%h exp=%h", bus.hi, 32'hFFFF_FFFF); end
        start_div(32'd7, 32'hFFFF_FFFE);
        wait_ready(lat);
        total++; if (bus.lo !== 32'hFFFF_FFFD) begin bad++; $display("FAIL neg_divisor_lo got=%h exp=%h", bus.lo, 32'hFFFF_FFFD); end
        total++; if (bus.hi !== 32'd1) begin bad++; $display("FAIL neg_divisor_hi got=%h exp=%h", bus.hi, 32'd1); end
    endtask

    task automatic test_div_zero;
        int lat;
        start_div(32'd7, 32'd2);
        wait_ready(lat);
        start_div(32'd5, 32'd0);
        wait_ready(lat);
        total++; if (lat !== 1) begin bad++; $display("FAIL dz_latency got=%0d exp=1", lat); end
        total++; if (bus.div_zero !== 1'b1) begin bad++; $display("FAIL dz_flag got=%b exp=1", bus.div_zero); end
        total++; if (bus.lo !== 32'd3) begin bad++; $display("FAIL dz_lo_kept got=%h exp=%h", bus.lo, 32'd3); end
        total++; if (bus.hi !== 32'd1) begin bad++; $display("FAIL dz_hi_kept got=%h exp=%h", bus.hi, 32'd1); end
        @(posedge clk); #1;
        total++; if (bus.ready !== 1'b0) begin bad++; $display("FAIL dz_ready_pulse got=%b exp=0", bus.ready); end
        total++; if (bus.div_zero !== 1'b0) begin bad++; $display("FAIL dz_flag_pulse got=%b exp=0", bus.div_zero); end
    endtask

    task automatic test_overflow;
        int lat;
        start_div(32'h8000_0000, 32'hFFFF_FFFF);
        wait_ready(lat);
        total++; if (bus.lo !== 32'h8000_0000) begin bad++; $display("FAIL ovf_lo got=%h exp=%h", bus.lo, 32'h8000_0000); end
        total++; if (bus.hi !== 32'h0) begin bad++; $display("FAIL ovf_hi got=%h exp=%h", bus.hi, 32'h0); end
        start_div(32'h8000_0000, 32'd1);
        wait_ready(lat);
        total++; if (bus.lo !== 32'h8000_0000) begin bad++; $display("FAIL minint_by_one_lo got=%h exp=%h", bus.lo, 32'h8000_0000); end
        total++; if (bus.hi !== 32'h0) begin bad++; $display("FAIL minint_by_one_hi got=%h exp=%h", bus.hi, 32'h0); end
    endtask

    task automatic test_back_to_back;
        int lat;
        int readies;
        start_div(32'd100, 32'd7);
        lat     = 1;
        readies = 0;
        while (!bus.ready && lat < 100) begin
            if (lat == 10) begin
                @(negedge clk);
                bus.a     = 32'd1;
                bus.b     = 32'd1;
                bus.start = 1'b1;
            end
            @(posedge clk);
            #1;
            bus.start = 1'b0;
            lat++;
        end
        total++; if (lat !== 34) begin bad++; $display("FAIL ignore_start_latency got=%0d exp=34", lat); end
        total++; if (bus.lo !== 32'd14) begin bad++; $display("FAIL ignore_start_lo got=%h exp=%h", bus.lo, 32'd14); end
        total++; if (bus.hi !== 32'd2) begin bad++; $display("FAIL ignore_start_hi got=%h exp=%h", bus.hi, 32'd2); end
        // Start asserted during the DONE cycle itself.
        bus.a     = 32'd9;
        bus.b     = 32'd3;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        lat = 1;
        while (lat < 34) begin
            if (bus.ready) readies++;
            @(posedge clk);
            #1;
            lat++;
        end
        total++; if (readies !== 0) begin bad++; $display("FAIL b2b_early_ready got=%0d exp=0", readies); end
        total++; if (bus.ready !== 1'b1) begin bad++; $display("FAIL b2b_ready got=%b exp=1", bus.ready); end
        total++; if (bus.lo !== 32'd3) begin bad++; $display("FAIL b2b_lo got=%h exp=%h", bus.lo, 32'd3); end
        total++; if (bus.hi !== 32'd0) begin bad++; $display("FAIL b2b_hi got=%h exp=%h", bus.hi, 32'd0); end
    endtask

    task automatic test_reset_mid;
        int lat;
        start_div(32'd1000, 32'd3);
        for (int i = 1; i < 15; i++) begin
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        total++; if (bus.hi !== 32'h0) begin bad++; $display("FAIL mid_reset_hi got=%h exp=%h", bus.hi, 32'h0); end
        total++; if (bus.lo !== 32'h0) begin bad++; $display("FAIL mid_reset_lo got=%h exp=%h", bus.lo, 32'h0); end
        total++; if (bus.ready !== 1'b0) begin bad++; $display("FAIL mid_reset_ready got=%b exp=0", bus.ready); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        start_div(32'd1000, 32'd3);
        wait_ready(lat);
        total++; if (lat !== 34) begin bad++; $display("FAIL after_reset_latency got=%0d exp=34", lat); end
        total++; if (bus.lo !== 32'd333) begin bad++; $display("FAIL after_reset_lo got=%h exp=%h", bus.lo, 32'd333); end
        total++; if (bus.hi !== 32'd1) begin bad++; $display("FAIL after_reset_hi got=%h exp=%h", bus.hi, 32'd1); end
    endtask

    initial begin
        reset     = 1'b0;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        #12;
        test_reset;
        test_basic;
        test_signed;
        test_div_zero;
        test_overflow;
        test_back_to_back;
        test_reset_mid;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Sequential signed 32-bit divider. It is the responder side of the CPU's start/ready handshake for DIV.
- The control unit pulses start with rs/rt already held in A/B. It waits for ready, then writes HI (remainder) and LO (quotient).
- Division by zero is reported on div_zero so the control unit can raise the exception path.
- Implementation is one quotient bit per cycle, restoring algorithm on operand magnitudes, with a final sign-correction cycle.

Parameters:
- WIDTH, 32, operand/result width; the counter is $clog2(WIDTH)+1 bits.
- SIGNED, 1, 1 = MIPS DIV semantics; 0 = unsigned (DIVU), which skips the magnitude/sign steps.

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled on rising edge; honoured only in IDLE or DONE.
- a  input  WIDTH  dividend, sampled when start is accepted.
- b  input  WIDTH  divisor, sampled when start is accepted.
- hi  output  WIDTH  remainder, registered.
- lo  output  WIDTH  quotient, registered.
- ready  output  1  one-cycle pulse: result (or div_zero) valid.
- div_zero  output  1  one-cycle pulse coincident with ready when b was 0.

Behaviour:
- Reset (reset low, any time, including mid-operation):
  - State goes to IDLE immediately.
  - hi, lo, internal remainder/quotient/divisor registers and counter are all 0.
  - ready = 0, div_zero = 0.
  - No partial result survives.
- States: IDLE, RUN, FIX, DONE.
- IDLE: start=1 at edge E0.
  - If b==0: go to DONE with div_zero_next=1. hi/lo are not modified.
  - Otherwise:
    - Latch |a| into the quotient shift register and |b| into the divisor register. In SIGNED mode this is two's-complement magnitude; 0x80000000 maps to 0x80000000 treated as unsigned.
    - Remainder register (WIDTH+1 bits) = 0.
    - Latch sign_q = a[31]^b[31] and sign_r = a[31].
    - Counter = 0; go to RUN.
- RUN: each edge performs one iteration.
  - Shift {rem, quo} left by 1.
  - Trial = rem - div.
  - If trial is non-negative: rem = trial, quo[0] = 1; else quo[0] = 0.
  - Counter increments; after the WIDTH-th iteration (edge E32) go to FIX.
- FIX (edge E33):
  - lo <= sign_q ? -quo : quo.
  - hi <= sign_r ? -rem : rem.
  - Go to DONE.
  - Quotient truncates toward zero; remainder takes the dividend's sign.
- DONE:
  - ready = 1 for exactly this cycle.
  - Next edge goes to IDLE, unless start=1, which is accepted exactly as in IDLE (back-to-back divides).
- Latency:
  - Normal: start edge E0, ready high in the cycle following E33, i.e. 34 cycles.
  - Divide by zero: ready and div_zero high in the cycle after E0, i.e. 1 cycle.
- hi/lo hold their value from FIX until the next FIX or reset. They are stable while the control unit writes HI/LO in any later cycle.
- start while in RUN or FIX is ignored. Operands and progress are unaffected and no second ready is generated.
- a and b may change after the start edge without effect.
- Overflow case 0x80000000 / 0xFFFFFFFF gives lo = 0x80000000, hi = 0. This is natural wrap; no flag is raised.
- ready and div_zero are registered outputs with no combinational path from start.
- SIGNED=0:
  - Magnitudes = raw operands; sign_q = sign_r = 0.
  - FIX is still spent, so latency is identical.

Test Plan:
- a=7, b=2, start pulse at E0 -> ready=1 exactly in cycle after E33; lo=0x00000003, hi=0x00000001; div_zero=0; ready low the next cycle.
- a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). Then a=7, b=0xFFFFFFFE (-2) -> lo=0xFFFFFFFD, hi=0x00000001.
- Prior result lo=3/hi=1; then a=5, b=0 -> ready=1 and div_zero=1 in the cycle after E0 for one cycle only; hi/lo remain 1/3.
- a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0. Then a=0x80000000, b=1 -> lo=0x80000000, hi=0.
- a=100, b=7 started; start re-pulsed at E10 with a=1, b=1 -> single ready after E33 with lo=14, hi=2. Start held high in the DONE cycle with a=9, b=3 -> second ready 34 cycles later, lo=3, hi=0.
- Start a=1000, b=3; drive reset low at E15 -> hi=lo=0, ready=0 asynchronously. After release, start a=1000, b=3 -> lo=333, hi=1 with full 34-cycle latency.
